// File: rtl/serial_ctrl_mc.sv
// Multi-channel serial controller: one bidirectional line carries command frames,
// channel writes into shadow registers, and shadow read-back; outputs latch on UPDATE.
module serial_ctrl_mc #(
    parameter int DATA_LEN    = 8,
    parameter int N_CH        = 4,
    parameter int CMD_LEN     = 3,
    parameter int RCV_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    inout  logic                       data_inout,
    output logic [N_CH*DATA_LEN-1:0]   bit_out,
    output logic                       busy,
    output logic                       err
);
    localparam int AW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int HW  = CMD_LEN + AW;
    localparam int CW  = $clog2(((HW > DATA_LEN) ? HW : DATA_LEN) + 1);
    localparam int TW  = $clog2(RCV_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_DEC, S_RCV_WAIT, S_RCV,
        S_SND_TA, S_SND_START, S_SND, S_SND_END
    } state_e;

    typedef enum logic [CMD_LEN-1:0] {
        CMD_NOP        = CMD_LEN'(0),
        CMD_RESET      = CMD_LEN'(1),
        CMD_START_RCV  = CMD_LEN'(2),
        CMD_UPDATE     = CMD_LEN'(3),
        CMD_START_SND  = CMD_LEN'(4),
        CMD_UPDATE_ALL = CMD_LEN'(5)
    } cmd_e;

    state_e                            state_q, state_d;
    logic [HW-1:0]                     hdr_q, hdr_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [TW-1:0]                     tmo_q, tmo_d;
    logic [DATA_LEN-1:0]               data_q, data_d;
    logic [N_CH-1:0][DATA_LEN-1:0]     shadow_q, shadow_d;
    logic [N_CH-1:0][DATA_LEN-1:0]     bit_out_q, bit_out_d;
    logic                              err_q, err_d;
    logic                              rst_sync_q;
    logic                              drive_en, drive_val;
    logic                              line_in;
    cmd_e                              cmd;
    logic [AW-1:0]                     addr;
    logic                              addr_ok;

    assign line_in    = data_inout;
    assign data_inout = drive_en ? drive_val : 1'bz;
    assign cmd        = cmd_e'(hdr_q[HW-1 -: CMD_LEN]);
    assign addr       = hdr_q[AW-1:0];
    assign addr_ok    = (32'(addr) < N_CH);
    assign bit_out    = bit_out_q;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;

    // Reset release is taken one edge late so the first start bit lands on the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 1'b0;
        else        rst_sync_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hdr_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            shadow_q  <= '0;
            bit_out_q <= '0;
            err_q     <= 1'b0;
        end else if (rst_sync_q) begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            shadow_q  <= shadow_d;
            bit_out_q <= bit_out_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        shadow_d  = shadow_q;
        bit_out_d = bit_out_q;
        err_d     = err_q;
        drive_en  = 1'b0;
        drive_val = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (line_in) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                end
            end
            S_HDR: begin
                hdr_d = {hdr_q[HW-2:0], line_in};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(HW - 1)) state_d = S_DEC;
            end
            S_DEC: begin
                state_d = S_IDLE;
                case (cmd)
                    CMD_NOP: ;
                    CMD_RESET: begin
                        shadow_d  = '0;
                        bit_out_d = '0;
                        err_d     = 1'b0;
                    end
                    CMD_START_RCV: begin
                        if (addr_ok) begin
                            state_d = S_RCV_WAIT;
                            tmo_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    CMD_UPDATE: begin
                        if (addr_ok) bit_out_d[addr] = shadow_q[addr];
                        else         err_d = 1'b1;
                    end
                    CMD_START_SND: begin
                        if (addr_ok) state_d = S_SND_TA;
                        else         err_d = 1'b1;
                    end
                    CMD_UPDATE_ALL: bit_out_d = shadow_q;
                    default:        err_d = 1'b1;
                endcase
            end
            S_RCV_WAIT: begin
                if (line_in) begin
                    state_d = S_RCV;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(RCV_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_RCV: begin
                data_d = {data_q[DATA_LEN-2:0], line_in};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_LEN - 1)) begin
                    shadow_d[addr] = data_d;
                    state_d        = S_IDLE;
                end
            end
            S_SND_TA: begin
                data_d  = shadow_q[addr];
                state_d = S_SND_START;
            end
            S_SND_START: begin
                drive_en  = 1'b1;
                drive_val = 1'b1;
                cnt_d     = '0;
                state_d   = S_SND;
            end
            S_SND: begin
                drive_en  = 1'b1;
                drive_val = data_q[DATA_LEN-1];
                data_d    = {data_q[DATA_LEN-2:0], 1'b0};
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_LEN - 1)) state_d = S_SND_END;
            end
            S_SND_END: begin
                drive_en  = 1'b1;
                drive_val = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_ctrl_mc.sv
// Randomized bench for serial_ctrl_mc against an array-based model of channel shadows and outputs.
module tb_serial_ctrl_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tb_en = 1'b0, tb_val = 1'b0, tb_sel = 1'b0;
    wire  line4, line3;
    logic [31:0] bit_out4;
    logic [23:0] bit_out3;
    logic busy4, err4, busy3, err3;

    assign line4 = (tb_en && !tb_sel) ? tb_val : 1'bz;
    assign line3 = (tb_en &&  tb_sel) ? tb_val : 1'bz;

    always #5 clk = ~clk;

    serial_ctrl_mc #(.DATA_LEN(8), .N_CH(4), .CMD_LEN(3), .RCV_TIMEOUT(64)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_inout(line4),
        .bit_out(bit_out4), .busy(busy4), .err(err4));

    serial_ctrl_mc #(.DATA_LEN(8), .N_CH(3), .CMD_LEN(3), .RCV_TIMEOUT(64)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_inout(line3),
        .bit_out(bit_out3), .busy(busy3), .err(err3));

    int unsigned n_vec = 0, n_miss = 0;
    logic [7:0] sh[4];
    logic [7:0] bo[4];
    logic       m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_bit_out();
        logic [31:0] v = '0;
        for (int c = 0; c < 4; c++) v = v | (32'(bo[c]) << (8 * c));
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            sh[c] = '0;
            bo[c] = '0;
        end
        m_err = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, " bit_out"}, bit_out4, model_bit_out());
        check({tag, " err"}, {31'b0, err4}, {31'b0, m_err});
        check({tag, " busy"}, {31'b0, busy4}, 32'd0);
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        tb_en  = 1'b1;
        tb_val = b;
    endtask

    // Start bit, command, address, then a filler bit for the decode cycle.
    task automatic send_hdr(input logic [2:0] cmd, input logic [1:0] a);
        drive_bit(1'b1);
        for (int i = 2; i >= 0; i--) drive_bit(cmd[i]);
        for (int i = 1; i >= 0; i--) drive_bit(a[i]);
        drive_bit(1'b0);
    endtask

    task automatic write_ch(input logic [1:0] a, input logic [7:0] v, input int gap);
        send_hdr(3'b010, a);
        repeat (gap) drive_bit(1'b0);
        drive_bit(1'b1);
        for (int i = 7; i >= 0; i--) drive_bit(v[i]);
        drive_bit(1'b0);
    endtask

    task automatic simple_cmd(input logic [2:0] cmd, input logic [1:0] a);
        send_hdr(cmd, a);
        drive_bit(1'b0);
    endtask

    task automatic do_send(input logic [1:0] a, input logic [7:0] exp);
        send_hdr(3'b100, a);
        @(negedge clk);
        tb_en = 1'b0;
        check("snd_ta busy", {31'b0, busy4}, 32'd1);
        @(negedge clk);
        check("snd start", {31'b0, line4}, 32'd1);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            check("snd data", {31'b0, line4}, {31'b0, exp[i]});
        end
        @(negedge clk);
        check("snd end", {31'b0, line4}, 32'd0);
        @(negedge clk);
        check("snd release busy", {31'b0, busy4}, 32'd0);
    endtask

    initial begin
        logic [1:0] a;
        logic [7:0] v;
        int op;
        model_reset();
        #2;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Write ch2 then UPDATE ch2
        write_ch(2'd2, 8'hA5, 0);
        sh[2] = 8'hA5;
        check_state("write ch2 no update");
        simple_cmd(3'b011, 2'd2);
        bo[2] = sh[2];
        check_state("update ch2");
        check("update ch2 literal", bit_out4, 32'h00A5_0000);

        do_send(2'd2, sh[2]);
        check_state("after send");

        // RESET then two writes and UPDATE_ALL
        simple_cmd(3'b001, 2'd3);
        model_reset();
        check_state("reset cmd");
        write_ch(2'd0, 8'h3C, 2);
        write_ch(2'd3, 8'hC3, 1);
        sh[0] = 8'h3C; sh[3] = 8'hC3;
        check_state("writes no update");
        simple_cmd(3'b101, 2'd0);
        for (int c = 0; c < 4; c++) bo[c] = sh[c];
        check("update_all literal", bit_out4, 32'hC300_003C);
        check_state("update_all");

        // Receive timeout on ch1: 63 idle samples keep waiting, the 64th aborts
        write_ch(2'd1, 8'h77, 0);
        sh[1] = 8'h77;
        send_hdr(3'b010, 2'd1);
        repeat (63) drive_bit(1'b0);
        drive_bit(1'b0);
        check("tmo 63 busy", {31'b0, busy4}, 32'd1);
        check("tmo 63 err", {31'b0, err4}, 32'd0);
        drive_bit(1'b0);
        m_err = 1'b1;
        check_state("tmo 64");
        do_send(2'd1, sh[1]);
        simple_cmd(3'b001, 2'd0);
        model_reset();
        check_state("reset clears err");

        // Undefined opcode
        write_ch(2'd0, 8'h81, 0);
        sh[0] = 8'h81;
        simple_cmd(3'b011, 2'd0);
        bo[0] = sh[0];
        simple_cmd(3'b111, 2'd1);
        m_err = 1'b1;
        check_state("opcode 111");

        // Asynchronous reset in the middle of a data word
        send_hdr(3'b010, 2'd2);
        drive_bit(1'b1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        @(negedge clk);
        tb_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_state("mid-frame reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        write_ch(2'd2, 8'h96, 1);
        sh[2] = 8'h96;
        simple_cmd(3'b011, 2'd2);
        bo[2] = sh[2];
        check_state("write after reset");

        // Randomized operation mix
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            a  = 2'($urandom_range(0, 3));
            v  = 8'($urandom);
            case (op)
                0, 1, 2: begin
                    write_ch(a, v, $urandom_range(0, 4));
                    sh[a] = v;
                end
                3, 4: begin
                    simple_cmd(3'b011, a);
                    bo[a] = sh[a];
                end
                5: begin
                    simple_cmd(3'b101, a);
                    for (int c = 0; c < 4; c++) bo[c] = sh[c];
                end
                6: do_send(a, sh[a]);
                7: simple_cmd(3'b000, a);
                8: begin
                    simple_cmd({2'b11, v[0]}, a);
                    m_err = 1'b1;
                end
                default: begin
                    if ($urandom_range(0, 2) == 0) begin
                        simple_cmd(3'b001, a);
                        model_reset();
                    end else begin
                        simple_cmd(3'b000, a);
                    end
                end
            endcase
            drive_bit(1'b0);
            check_state("random");
        end

        // Three-channel build: address 3 is out of range
        tb_sel = 1'b1;
        drive_bit(1'b0);
        check("n3 err init", {31'b0, err3}, 32'd0);
        simple_cmd(3'b010, 2'd3);
        check("n3 bad addr err", {31'b0, err3}, 32'd1);
        check("n3 bad addr busy", {31'b0, busy3}, 32'd0);
        simple_cmd(3'b101, 2'd0);
        check("n3 shadows untouched", {8'b0, bit_out3}, 32'd0);
        write_ch(2'd2, 8'h5A, 0);
        simple_cmd(3'b011, 2'd2);
        check("n3 ch2 update", {8'b0, bit_out3}, 32'h005A_0000);
        simple_cmd(3'b011, 2'd3);
        check("n3 bad update", {8'b0, bit_out3}, 32'h005A_0000);
        check("n3 err sticky", {31'b0, err3}, 32'd1);
        tb_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
